// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and encodings for the RV32I decode-stage hazard
// controller (hazard_ctrl) and its scoreboard (hazard_scoreboard).
//   - Register-address, forwarding-select and PC-select widths and codes
//   - state_t   : pipeline sequencer state {RUN, MEMWAIT}
//   - sb_slot_t : one in-flight destination record {rd, wr, load}
//   - slot_match: source/slot match rule (x0 never matches)
package hazard_pkg;

    localparam int REG_ADDR_WIDTH    = 5;
    localparam int FORWARD_SEL_WIDTH = 2;
    localparam int PC_SEL_WIDTH      = 2;

    // Branch-operand forwarding selects; EXE means "use the regfile value".
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_EXE = 2'd0;
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_MEM = 2'd1;
    localparam logic [FORWARD_SEL_WIDTH-1:0] FORWARD_SEL_WB  = 2'd2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BR    = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL   = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR  = 2'd3;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr;
        logic                      load;
    } sb_slot_t;

    function automatic logic slot_match(input sb_slot_t s,
                                        input logic [REG_ADDR_WIDTH-1:0] rs);
        return s.wr && (s.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: 3-slot shadow of the EXE/MEM/WB destination fields.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (all slots zero)
//   advance       shift this cycle (low while the pipe is frozen)
//   bubble        load an empty slot into EXE instead of din
//   din           destination record of the instruction leaving decode
//   exe, mem, wb  current slot contents
import hazard_pkg::*;

module hazard_scoreboard (
    input  logic     clk,
    input  logic     rst,
    input  logic     advance,
    input  logic     bubble,
    input  sb_slot_t din,
    output sb_slot_t exe,
    output sb_slot_t mem,
    output sb_slot_t wb
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (advance) begin
            wb  <= mem;
            mem <= exe;
            exe <= bubble ? '0 : din;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I decode-stage pipeline sequencer.
// Tracks in-flight destinations, drives branch-operand forwarding selects,
// load-use / branch-operand stalls, ID/EXE bubbles, IF/ID kills on redirect,
// PC select, and a whole-pipe freeze while data memory is not ready.
// Parameter:
//   MAX_WAIT    consecutive mem_ready-low cycles before mem_timeout (0 = never)
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   id_rs1_addr/id_rs2_addr          decode sources, id_use_rs1/2 their use
//   id_rd_addr, id_reg_write         decode destination
//   id_is_load/branch/jal/jalr       decode instruction class
//   br_true                          branch comparator result
//   mem_ready                        data memory completes this cycle
//   branch_a_sel/branch_b_sel        forwarding selects for the ID comparator
//   stall_if, stall_id, flush_id     hold PC, hold IF/ID, bubble into ID/EXE
//   flush_if                         kill IF/ID on redirect
//   freeze                           hold every pipeline register
//   pc_sel                           PC_SEL_PLUS4/BR/JAL/JALR
//   state                            sequencer state (debug visibility)
//   mem_timeout                      sticky memory-wait timeout
// Optional macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters
//   stall_cnt (stall cycles), flush_cnt (redirect flushes),
//   wait_cnt (MEMWAIT cycles).
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rs2_addr,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rd_addr,
    input  logic                         id_reg_write,
    input  logic                         id_is_load,
    input  logic                         id_is_branch,
    input  logic                         id_is_jal,
    input  logic                         id_is_jalr,
    input  logic                         br_true,
    input  logic                         mem_ready,
    output logic [FORWARD_SEL_WIDTH-1:0] branch_a_sel,
    output logic [FORWARD_SEL_WIDTH-1:0] branch_b_sel,
    output logic                         stall_if,
    output logic                         stall_id,
    output logic                         flush_id,
    output logic                         flush_if,
    output logic                         freeze,
    output logic [PC_SEL_WIDTH-1:0]      pc_sel,
    output state_t                       state,
    output logic                         mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  flush_cnt,
    output logic [31:0]                  wait_cnt
`endif
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    sb_slot_t sb_exe, sb_mem, sb_wb;
    sb_slot_t id_slot;
    state_t   state_next;
    logic     ctrl_in_id;
    logic     m_exe1, m_exe2, m_mem1, m_mem2;
    logic     hazard;
    logic [CW-1:0] wait_count, wait_inc;

    assign id_slot = '{rd: id_rd_addr, wr: id_reg_write, load: id_is_load};

    // Shift only when not frozen; a stalled decode leaves a bubble behind.
    hazard_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .advance (!freeze),
        .bubble  (hazard),
        .din     (id_slot),
        .exe     (sb_exe),
        .mem     (sb_mem),
        .wb      (sb_wb)
    );

    // Loads in MEM are not forwardable yet; those cases are stalled instead.
    function automatic logic [FORWARD_SEL_WIDTH-1:0] fwd_sel(
        input logic                      use_src,
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input sb_slot_t                  mem_s,
        input sb_slot_t                  wb_s
    );
        if (use_src && slot_match(mem_s, rs) && !mem_s.load) return FORWARD_SEL_MEM;
        if (use_src && slot_match(wb_s, rs))                 return FORWARD_SEL_WB;
        return FORWARD_SEL_EXE;
    endfunction

    always_comb begin
        ctrl_in_id = id_is_branch | id_is_jalr;
        m_exe1     = id_use_rs1 && slot_match(sb_exe, id_rs1_addr);
        m_exe2     = id_use_rs2 && slot_match(sb_exe, id_rs2_addr);
        m_mem1     = id_use_rs1 && slot_match(sb_mem, id_rs1_addr);
        m_mem2     = id_use_rs2 && slot_match(sb_mem, id_rs2_addr);
        hazard     = (sb_exe.load && (m_exe1 || m_exe2))
                   || (ctrl_in_id && (m_exe1 || m_exe2))
                   || (ctrl_in_id && sb_mem.load && (m_mem1 || m_mem2));
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // Next state and outputs. freeze follows mem_ready directly so the first
    // wait cycle is already frozen; priority is freeze > stall > redirect.
    always_comb begin
        state_next   = mem_ready ? RUN : MEMWAIT;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        flush_id     = 1'b0;
        flush_if     = 1'b0;
        freeze       = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        branch_a_sel = FORWARD_SEL_EXE;
        branch_b_sel = FORWARD_SEL_EXE;
        if (rst) begin
            if (ctrl_in_id) begin
                branch_a_sel = fwd_sel(id_use_rs1, id_rs1_addr, sb_mem, sb_wb);
                branch_b_sel = fwd_sel(id_use_rs2, id_rs2_addr, sb_mem, sb_wb);
            end
            if (!mem_ready) begin
                freeze   = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (hazard) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_id = 1'b1;
            end else if (id_is_jal) begin
                pc_sel   = PC_SEL_JAL;
                flush_if = 1'b1;
            end else if (id_is_jalr) begin
                pc_sel   = PC_SEL_JALR;
                flush_if = 1'b1;
            end else if (id_is_branch && br_true) begin
                pc_sel   = PC_SEL_BR;
                flush_if = 1'b1;
            end
        end
    end

    // Counts consecutive mem_ready-low cycles, saturating at MAX_WAIT.
    assign wait_inc = (wait_count == WAIT_LIMIT) ? wait_count : wait_count + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_count  <= '0;
            mem_timeout <= 1'b0;
        end else if (!mem_ready) begin
            wait_count <= wait_inc;
            if ((MAX_WAIT != 0) && (wait_inc == WAIT_LIMIT)) mem_timeout <= 1'b1;
        end else begin
            wait_count <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (flush_id)         stall_cnt <= stall_cnt + 32'd1;
            if (flush_if)         flush_cnt <= flush_cnt + 32'd1;
            if (state == MEMWAIT) wait_cnt  <= wait_cnt + 32'd1;
        end
    end
`endif

endmodule
